buffer_reader: RTL and testbench



---
 rtl/buffer_reader.sv | 133 +++++++++++++
 tb/tb_buffer_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// Read-side controller for a multichannel circular-buffer RAM: round-robin issue,
// read-latency absorption into a small output FIFO, and released read pointers.
module buffer_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned OBUF_DEPTH = 4,
  localparam int unsigned CH_BITS   = $clog2(NUM_CH),
  localparam int unsigned PW        = ADDR_WIDTH - CH_BITS + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*PW-1:0]   wr_ptr_i,
  output logic [NUM_CH*PW-1:0]   rd_ptr_o,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [CH_BITS-1:0]     m_chan
);

  localparam int unsigned IDX_W = $clog2(OBUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 2;

  logic [PW-1:0]         r_issue_ptr [NUM_CH];
  logic [PW-1:0]         r_rel_ptr   [NUM_CH];
  logic [CH_BITS-1:0]    r_rr;
  logic                  r_s1_vld, r_s2_vld;
  logic [CH_BITS-1:0]    r_s1_ch, r_s2_ch;
  logic [DATA_WIDTH-1:0] r_mem_data [OBUF_DEPTH];
  logic [CH_BITS-1:0]    r_mem_ch   [OBUF_DEPTH];
  logic [IDX_W-1:0]      r_wr_idx, r_rd_idx;
  logic [CNT_W-1:0]      r_count;

  logic [NUM_CH-1:0]     w_nonempty;
  logic                  w_found;
  logic [CH_BITS-1:0]    w_grant;
  logic [CH_BITS-1:0]    w_cand;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(OBUF_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_nonempty[c] = wr_ptr_i[c*PW +: PW] != r_issue_ptr[c];
    end
  end

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = r_rr + CH_BITS'(i);
      if (!w_found && w_nonempty[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  // Words in flight reserve FIFO space; a same-cycle pop gives no credit.
  assign w_occ   = OCC_W'(r_count) + OCC_W'(r_s1_vld) + OCC_W'(r_s2_vld);
  assign w_issue = w_found && (w_occ < OCC_W'(OBUF_DEPTH));
  assign w_push  = r_s2_vld;
  assign w_pop   = m_valid && m_ready;

  assign m_valid = (r_count != '0);
  assign m_data  = r_mem_data[r_rd_idx];
  assign m_chan  = r_mem_ch[r_rd_idx];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rd_ptr
    assign rd_ptr_o[c*PW +: PW] = r_rel_ptr[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_issue_ptr[c] <= '0;
        r_rel_ptr[c]   <= '0;
      end
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_ch[i]   <= '0;
      end
      r_rr     <= '0;
      rd_addr  <= '0;
      r_s1_vld <= 1'b0;
      r_s1_ch  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_ch  <= '0;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_issue) begin
        rd_addr              <= {w_grant, r_issue_ptr[w_grant][PW-2:0]};
        r_issue_ptr[w_grant] <= r_issue_ptr[w_grant] + PW'(1);
        r_rr                 <= w_grant;
      end
      r_s1_vld <= w_issue;
      r_s1_ch  <= w_grant;
      r_s2_vld <= r_s1_vld;
      r_s2_ch  <= r_s1_ch;
      // Release only once the RAM has registered the address.
      if (r_s1_vld) begin
        r_rel_ptr[r_s1_ch] <= r_rel_ptr[r_s1_ch] + PW'(1);
      end
      if (w_push) begin
        r_mem_data[r_wr_idx] <= rd_data;
        r_mem_ch[r_wr_idx]   <= r_s2_ch;
        r_wr_idx             <= f_next(r_wr_idx);
      end
      if (w_pop) begin
        r_rd_idx <= f_next(r_rd_idx);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Bench for buffer_reader: RAM and writer models, per-channel word scoreboard,
// directed scenarios followed by a randomized traffic phase.
module tb_buffer_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NC = 4;
  localparam int CB = 2;
  localparam int PW = 9;
  localparam int RD = 256;

  typedef struct {
    int          ch;
    logic [31:0] d;
  } ent_t;

  logic           clk;
  logic           rst;
  logic [NC*PW-1:0] wr_ptr_i;
  logic [NC*PW-1:0] rd_ptr_o;
  logic [AW-1:0]  rd_addr;
  logic [DW-1:0]  rd_data;
  logic           m_valid;
  logic           m_ready;
  logic [DW-1:0]  m_data;
  logic [CB-1:0]  m_chan;

  logic [31:0] ram [1024];
  logic [8:0]  wp [NC];
  ent_t        q[$];
  int          seq[$];
  int          stamp[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          emitted = 0;
  bit          stall_prev = 0;
  logic [31:0] prev_data;
  logic [1:0]  prev_chan;

  buffer_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC), .OBUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .wr_ptr_i(wr_ptr_i), .rd_ptr_o(rd_ptr_o), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_chan(m_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: address registered, data valid the following cycle.
  always @(posedge clk) rd_data <= ram[rd_addr];

  assign wr_ptr_i = {wp[3], wp[2], wp[1], wp[0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] rel(input int c);
    return rd_ptr_o[c*PW +: PW];
  endfunction

  task automatic write_word(input int c, input logic [31:0] d, output bit ok);
    logic [8:0] occ;
    logic [1:0] cc;
    cc  = c[1:0];
    occ = wp[c] - rel(c);
    ok  = 1'b0;
    if (occ < 9'(RD)) begin
      ram[{cc, wp[c][7:0]}] = d;
      q.push_back('{c, d});
      wp[c] = wp[c] + 9'd1;
      ok = 1'b1;
    end
  endtask

  // Scores the transfer about to happen at the next rising edge, then advances.
  task automatic cycle();
    int idx;
    if (stall_prev) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, prev_data);
      chk("hold_chan", m_chan, prev_chan);
    end
    if (m_valid === 1'b1 && m_ready === 1'b1 && !rst) begin
      idx = -1;
      for (int i = 0; i < q.size(); i++) begin
        if (idx < 0 && q[i].ch == int'(m_chan)) idx = i;
      end
      chk("word_expected", idx >= 0, 1);
      if (idx >= 0) begin
        chk("word_data", m_data, q[idx].d);
        q.delete(idx);
      end
      emitted++;
      seq.push_back(int'(m_chan));
      stamp.push_back(cyc);
    end
    stall_prev = (m_valid === 1'b1) && !m_ready && !rst;
    prev_data  = m_data;
    prev_chan  = m_chan;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int n = 0; n < 2000 && (q.size() != 0 || m_valid !== 1'b0); n++) cycle();
    chk("drain_empty", q.size(), 0);
    chk("drain_idle", m_valid, 0);
  endtask

  initial begin
    bit ok;
    int base;
    int written;
    rst = 1'b1;
    m_ready = 1'b0;
    for (int c = 0; c < NC; c++) wp[c] = '0;
    @(negedge clk);

    // Reset with pending ch1 data
    cycle();
    for (int i = 0; i < 5; i++) write_word(1, $urandom, ok);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_valid", m_valid, 0);
      chk("rst_addr", rd_addr, 0);
      chk("rst_rdptr", rd_ptr_o, 0);
    end
    chk("rst_data", m_data, 0);
    chk("rst_chan", m_chan, 0);
    rst = 1'b0;
    seq.delete();
    emitted = 0;
    drain();
    chk("t1_count", emitted, 5);
    for (int i = 0; i < seq.size(); i++) chk("t1_chan", seq[i], 1);

    // Single word latency on ch2
    write_word(2, 32'hA5A50001, ok);
    cycle();
    chk("single_addr", rd_addr, 10'h200);
    chk("single_nopre_rel", rel(2), 0);
    cycle();
    chk("single_rel", rel(2), 1);
    chk("single_notyet", m_valid, 0);
    cycle();
    chk("single_valid", m_valid, 1);
    chk("single_data", m_data, 32'hA5A50001);
    chk("single_chan", m_chan, 2);
    drain();

    // Round-robin between ch0 and ch1
    seq.delete();
    stamp.delete();
    for (int i = 0; i < 3; i++) begin
      write_word(0, $urandom, ok);
      write_word(1, $urandom, ok);
    end
    drain();
    chk("rr_count", seq.size(), 6);
    for (int i = 0; i < seq.size(); i++) begin
      chk("rr_chan", seq[i], i % 2);
      chk("rr_back2back", stamp[i] - stamp[0], i);
    end

    // Backpressure on ch0
    m_ready = 1'b0;
    base = int'(wp[0]);
    emitted = 0;
    for (int i = 0; i < 8; i++) write_word(0, $urandom, ok);
    repeat (10) cycle();
    chk("bp_released", rel(0), 9'(base + 4));
    chk("bp_last_addr", rd_addr, {2'b00, 8'(base + 3)});
    chk("bp_valid", m_valid, 1);
    drain();
    chk("bp_total", emitted, 8);

    // Fill ch3 up to offset 0xFE under random backpressure, then cross the wrap
    written = 0;
    for (int n = 0; n < 3000 && written < 254; n++) begin
      write_word(3, $urandom, ok);
      if (ok) written++;
      m_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("wrap_fill", written, 254);
    drain();
    for (int i = 0; i < 3; i++) write_word(3, $urandom, ok);
    cycle();
    chk("wrap_addr0", rd_addr, 10'h3FE);
    cycle();
    chk("wrap_addr1", rd_addr, 10'h3FF);
    cycle();
    chk("wrap_addr2", rd_addr, 10'h300);
    drain();
    chk("wrap_rel", rel(3), 9'h101);

    // Reset with two words in flight and two buffered
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_word(0, $urandom, ok);
    repeat (4) cycle();
    chk("mid_buffered", m_valid, 1);
    rst = 1'b1;
    cycle();
    chk("mid_valid", m_valid, 0);
    chk("mid_rdptr", rd_ptr_o, 0);
    chk("mid_addr", rd_addr, 0);
    q.delete();
    for (int c = 0; c < NC; c++) wp[c] = '0;
    cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    emitted = 0;
    repeat (10) cycle();
    chk("mid_no_stale", emitted, 0);
    chk("mid_idle", m_valid, 0);

    // Randomized traffic on all channels
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 2) == 0) write_word(c, $urandom, ok);
      end
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();
    for (int c = 0; c < NC; c++) chk("rand_rel", rel(c), wp[c]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
